// File: rtl/idu_stage_if.sv
// Decoded-instruction bus from the decode stage to the execute stage.
// Master is the producer (IDU) and slave is the consumer (EXU).
interface idu_stage_if #(
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned COMMAND_WIDTH = 4
);
  logic                     valid;
  logic                     ready;
  logic [DATA_WIDTH-1:0]    pc;
  logic [DATA_WIDTH-1:0]    src1;
  logic [DATA_WIDTH-1:0]    src2;
  logic [DATA_WIDTH-1:0]    imm;
  logic [ADDR_WIDTH-1:0]    des;
  logic [COMMAND_WIDTH-1:0] command;
  logic [5:0]               imm_type;
  logic                     illegal;

  modport master (
    output valid, pc, src1, src2, imm, des, command, imm_type, illegal,
    input  ready
  );

  modport slave (
    input  valid, pc, src1, src2, imm, des, command, imm_type, illegal,
    output ready
  );
endinterface

// File: rtl/idu_stage.sv
// RV32 decode stage: single-entry pipeline register between IFU and EXU that
// decodes opcode/immediate, samples regfile operands and counts accepted instructions.
module idu_stage #(
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned COMMAND_WIDTH = 4,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [31:0]           in_inst_i,
  input  logic [DATA_WIDTH-1:0] in_pc_i,
  output logic [ADDR_WIDTH-1:0] raddr1_o,
  output logic [ADDR_WIDTH-1:0] raddr2_o,
  input  logic [DATA_WIDTH-1:0] rdata1_i,
  input  logic [DATA_WIDTH-1:0] rdata2_i,
  input  logic                  flush_i,
  output logic [CNT_WIDTH-1:0]  decode_cnt_o,
  idu_stage_if.master           out_if
);

  typedef enum logic [6:0] {
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  typedef enum logic [5:0] {
    IT_NONE = 6'b000000,
    IT_R    = 6'b000001,
    IT_I    = 6'b000010,
    IT_S    = 6'b000100,
    IT_B    = 6'b001000,
    IT_U    = 6'b010000,
    IT_J    = 6'b100000
  } imm_type_e;

  logic                     capture;
  logic                     valid_d, valid_q;
  logic [CNT_WIDTH-1:0]     cnt_q;
  logic [DATA_WIDTH-1:0]    pc_q, src1_q, src2_q, imm_q, imm_d;
  logic [ADDR_WIDTH-1:0]    des_q, des_d;
  logic [COMMAND_WIDTH-1:0] cmd_q, cmd_d;
  imm_type_e                type_q, type_d;
  logic                     illegal_q, illegal_d;
  logic [31:0]              imm32;

  assign raddr1_o   = ADDR_WIDTH'(in_inst_i[19:15]);
  assign raddr2_o   = ADDR_WIDTH'(in_inst_i[24:20]);
  assign in_ready_o = (!valid_q || out_if.ready) && !flush_i;
  assign capture    = in_valid_i && in_ready_o;

  always_comb begin
    cmd_d     = '0;
    type_d    = IT_NONE;
    illegal_d = 1'b0;
    des_d     = ADDR_WIDTH'(in_inst_i[11:7]);
    unique case (in_inst_i[6:0])
      OPC_OPIMM:  begin cmd_d = COMMAND_WIDTH'(1);  type_d = IT_I; end
      OPC_OP:     begin cmd_d = COMMAND_WIDTH'(2);  type_d = IT_R; end
      OPC_LOAD:   begin cmd_d = COMMAND_WIDTH'(3);  type_d = IT_I; end
      OPC_STORE:  begin cmd_d = COMMAND_WIDTH'(4);  type_d = IT_S; des_d = '0; end
      OPC_BRANCH: begin cmd_d = COMMAND_WIDTH'(5);  type_d = IT_B; des_d = '0; end
      OPC_LUI:    begin cmd_d = COMMAND_WIDTH'(6);  type_d = IT_U; end
      OPC_AUIPC:  begin cmd_d = COMMAND_WIDTH'(7);  type_d = IT_U; end
      OPC_JAL:    begin cmd_d = COMMAND_WIDTH'(8);  type_d = IT_J; end
      OPC_JALR:   begin cmd_d = COMMAND_WIDTH'(9);  type_d = IT_I; end
      OPC_SYSTEM: begin cmd_d = COMMAND_WIDTH'(10); type_d = IT_I; end
      default:    begin illegal_d = 1'b1; des_d = '0; end
    endcase
  end

  // Immediate is assembled at 32 bits, then sign-extended to DATA_WIDTH.
  always_comb begin
    imm32 = '0;
    unique case (type_d)
      IT_I: imm32 = {{20{in_inst_i[31]}}, in_inst_i[31:20]};
      IT_S: imm32 = {{20{in_inst_i[31]}}, in_inst_i[31:25], in_inst_i[11:7]};
      IT_B: imm32 = {{19{in_inst_i[31]}}, in_inst_i[31], in_inst_i[7],
                     in_inst_i[30:25], in_inst_i[11:8], 1'b0};
      IT_U: imm32 = {in_inst_i[31:12], 12'b0};
      IT_J: imm32 = {{11{in_inst_i[31]}}, in_inst_i[31], in_inst_i[19:12],
                     in_inst_i[20], in_inst_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm_d = DATA_WIDTH'($signed(imm32));
  end

  always_comb begin
    valid_d = valid_q;
    if (flush_i)                     valid_d = 1'b0;
    else if (capture)                valid_d = 1'b1;
    else if (valid_q && out_if.ready) valid_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      pc_q      <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      imm_q     <= '0;
      des_q     <= '0;
      cmd_q     <= '0;
      type_q    <= IT_NONE;
      illegal_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (capture) begin
        cnt_q     <= cnt_q + 1'b1;
        pc_q      <= in_pc_i;
        src1_q    <= rdata1_i;
        src2_q    <= rdata2_i;
        imm_q     <= imm_d;
        des_q     <= des_d;
        cmd_q     <= cmd_d;
        type_q    <= type_d;
        illegal_q <= illegal_d;
      end
    end
  end

  assign out_if.valid    = valid_q;
  assign out_if.pc       = pc_q;
  assign out_if.src1     = src1_q;
  assign out_if.src2     = src2_q;
  assign out_if.imm      = imm_q;
  assign out_if.des      = des_q;
  assign out_if.command  = cmd_q;
  assign out_if.imm_type = type_q;
  assign out_if.illegal  = illegal_q;
  assign decode_cnt_o    = cnt_q;

endmodule

// File: tb/tb_idu_stage.sv
// Directed bench for idu_stage: decode vectors, backpressure, flush, async reset
// and counter wrap on a second instance with a 3-bit counter.
module tb_idu_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, flush;
  logic [31:0] in_inst, in_pc;
  logic        in_ready, in_ready2;
  logic [4:0]  raddr1, raddr2, raddr1_2, raddr2_2;
  logic [31:0] rdata1, rdata2;
  logic [31:0] cnt;
  logic [2:0]  cnt2;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  // Regfile stand-in: x0 reads zero, xN reads 0x1000+N.
  function automatic logic [31:0] rf(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : (32'h1000 + 32'(a));
  endfunction

  assign rdata1 = rf(raddr1);
  assign rdata2 = rf(raddr2);

  idu_stage_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .COMMAND_WIDTH(4)) bus  ();
  idu_stage_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .COMMAND_WIDTH(4)) bus2 ();
  assign bus.ready  = out_ready;
  assign bus2.ready = out_ready;

  idu_stage #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .COMMAND_WIDTH(4), .CNT_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_inst_i(in_inst), .in_pc_i(in_pc), .raddr1_o(raddr1), .raddr2_o(raddr2),
    .rdata1_i(rdata1), .rdata2_i(rdata2), .flush_i(flush), .decode_cnt_o(cnt),
    .out_if(bus)
  );

  idu_stage #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .COMMAND_WIDTH(4), .CNT_WIDTH(3)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready2),
    .in_inst_i(in_inst), .in_pc_i(in_pc), .raddr1_o(raddr1_2), .raddr2_o(raddr2_2),
    .rdata1_i(rdata1), .rdata2_i(rdata2), .flush_i(flush), .decode_cnt_o(cnt2),
    .out_if(bus2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  cmd;
    logic [5:0]  ty;
    logic [31:0] imm;
    logic [4:0]  des;
    logic        ill;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] vi;
    vecs[0] = '{32'h00500093, 4'd1, 6'h02, 32'h00000005, 5'd1, 1'b0}; // addi x1,x0,5
    vecs[1] = '{32'h00112223, 4'd4, 6'h04, 32'h00000004, 5'd0, 1'b0}; // sw x1,4(x2)
    vecs[2] = '{32'hFE000EE3, 4'd5, 6'h08, 32'hFFFFFFFC, 5'd0, 1'b0}; // beq x0,x0,-4
    vecs[3] = '{32'hFFFFFFFF, 4'd0, 6'h00, 32'h00000000, 5'd0, 1'b1}; // illegal
    vecs[4] = '{32'h123452B7, 4'd6, 6'h10, 32'h12345000, 5'd5, 1'b0}; // lui x5,0x12345
    vecs[5] = '{32'h008000EF, 4'd8, 6'h20, 32'h00000008, 5'd1, 1'b0}; // jal x1,8
    vecs[6] = '{32'h002081B3, 4'd2, 6'h01, 32'h00000000, 5'd3, 1'b0}; // add x3,x1,x2

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h8000_0000;
    @(negedge clk); @(negedge clk);
    chk("rst_valid", 64'(bus.valid), 64'd0);
    chk("rst_cnt",   64'(cnt), 64'd0);
    chk("rst_imm",   64'(bus.imm), 64'd0);
    chk("rst_cmd",   64'(bus.command), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      vi       = vecs[i].inst;
      in_inst  = vi;
      in_pc    = 32'h8000_0000 + 32'(4 * i);
      in_valid = 1'b1;
      #1;
      if (i == 0) chk("post_rst_ready", 64'(in_ready), 64'd1);
      if (i == 1) begin
        chk("sw_raddr1", 64'(raddr1), 64'd2);
        chk("sw_raddr2", 64'(raddr2), 64'd1);
      end
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), 64'(bus.valid), 64'd1);
      chk($sformatf("v%0d_cmd", i),   64'(bus.command), 64'(vecs[i].cmd));
      chk($sformatf("v%0d_type", i),  64'(bus.imm_type), 64'(vecs[i].ty));
      chk($sformatf("v%0d_imm", i),   64'(bus.imm), 64'(vecs[i].imm));
      chk($sformatf("v%0d_des", i),   64'(bus.des), 64'(vecs[i].des));
      chk($sformatf("v%0d_ill", i),   64'(bus.illegal), 64'(vecs[i].ill));
      chk($sformatf("v%0d_pc", i),    64'(bus.pc), 64'(32'h8000_0000 + 32'(4 * i)));
      chk($sformatf("v%0d_src1", i),  64'(bus.src1), 64'(rf(vi[19:15])));
      chk($sformatf("v%0d_src2", i),  64'(bus.src2), 64'(rf(vi[24:20])));
      chk($sformatf("v%0d_cnt", i),   64'(cnt), 64'(i + 1));
    end

    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_valid", 64'(bus.valid), 64'd0);
    chk("drain_cnt",   64'(cnt), 64'd7);
    chk("cnt3_7",      64'(cnt2), 64'd7);

    // Backpressure: hold for three cycles, then zero-bubble transfer+capture.
    in_valid = 1'b1; in_inst = 32'h00500093;
    @(negedge clk);
    chk("bp_cnt",   64'(cnt), 64'd8);
    chk("cnt3_wrap", 64'(cnt2), 64'd0);
    out_ready = 1'b0; in_inst = 32'h00112223;
    #1 chk("bp_in_ready", 64'(in_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(bus.valid), 64'd1);
      chk("bp_hold_imm",   64'(bus.imm), 64'd5);
      chk("bp_hold_cmd",   64'(bus.command), 64'd1);
      chk("bp_hold_cnt",   64'(cnt), 64'd8);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("bp_new_valid", 64'(bus.valid), 64'd1);
    chk("bp_new_cmd",   64'(bus.command), 64'd4);
    chk("bp_new_imm",   64'(bus.imm), 64'd4);
    chk("bp_new_cnt",   64'(cnt), 64'd9);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_drain_cnt", 64'(cnt), 64'd9);

    // Flush with a pending valid and a new instruction on offer.
    in_valid = 1'b1; in_inst = 32'h00500093;
    @(negedge clk);
    chk("fl_pre_valid", 64'(bus.valid), 64'd1);
    chk("fl_pre_cnt",   64'(cnt), 64'd10);
    flush = 1'b1; out_ready = 1'b0;
    #1 chk("fl_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("fl_valid", 64'(bus.valid), 64'd0);
    chk("fl_cnt",   64'(cnt), 64'd10);
    flush = 1'b0; out_ready = 1'b1;

    // Asynchronous reset between clock edges.
    in_valid = 1'b1; in_inst = 32'h123452B7;
    @(negedge clk);
    chk("ar_pre_cnt",  64'(cnt), 64'd11);
    chk("ar_pre_cnt3", 64'(cnt2), 64'd3);
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #2 chk("ar_held_valid", 64'(bus.valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(bus.valid), 64'd0);
    chk("ar_cnt",   64'(cnt), 64'd0);
    chk("ar_cnt3",  64'(cnt2), 64'd0);
    chk("ar_imm",   64'(bus.imm), 64'd0);
    chk("ar_des",   64'(bus.des), 64'd0);
    chk("ar_cmd",   64'(bus.command), 64'd0);
    chk("ar_pc",    64'(bus.pc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h008000EF;
    @(negedge clk);
    chk("re_cmd", 64'(bus.command), 64'd8);
    chk("re_cnt", 64'(cnt), 64'd1);
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/idu_stage.md
IDU_STAGE -- requirements
Module: ysyx_24120013_idu_stage

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, register address width.
REQ-002 Parameter DATA_WIDTH, default 32, operand/immediate/PC width; SHALL be >= 32.
REQ-003 Parameter COMMAND_WIDTH, default 4, command code width; SHALL be >= 4.
REQ-004 Parameter CNT_WIDTH, default 32, decoded-instruction counter width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  upstream (IFU) instruction valid.
REQ-008 in_ready  output  1  stage can accept an instruction this cycle.
REQ-009 in_inst  input  32  instruction word; in_pc  input  DATA_WIDTH  its PC.
REQ-010 raddr1, raddr2  output  ADDR_WIDTH  regfile read addresses; rdata1, rdata2  input  DATA_WIDTH  combinational read data.
REQ-011 flush  input  1  discard held instruction (redirect).
REQ-012 out_valid  output  1; out_ready  input  1  downstream (EXU) handshake.
REQ-013 out_pc, out_src1, out_src2, out_imm  output  DATA_WIDTH; out_des  output  ADDR_WIDTH; out_command  output  COMMAND_WIDTH; out_imm_type  output  6 (one-hot R/I/S/B/U/J = bit0..bit5); out_illegal  output  1.
REQ-014 decode_cnt  output  CNT_WIDTH  count of accepted instructions.

Function
REQ-015 raddr1 SHALL equal in_inst[19:15], raddr2 in_inst[24:20], combinationally, zero-extended to ADDR_WIDTH.
REQ-016 in_ready SHALL be (!out_valid || out_ready) && !flush.
REQ-017 Capture: when in_valid && in_ready, all out_* payload registers SHALL load the decode of in_inst, rdata1/rdata2 and in_pc at the edge; out_valid set to 1.
REQ-018 Transfer: when out_valid && out_ready and no capture, out_valid SHALL clear next edge; simultaneous transfer and capture keeps out_valid=1 with new payload (zero-bubble, latency 1 cycle).
REQ-019 Hold: while out_valid && !out_ready, all out_* SHALL remain stable.
REQ-020 Flush: flush=1 SHALL clear out_valid next edge, overriding capture and transfer; payload need not clear.
REQ-021 Opcode -> command/imm_type: 0010011 OP-IMM 1/I; 0110011 OP 2/R; 0000011 LOAD 3/I; 0100011 STORE 4/S; 1100011 BRANCH 5/B; 0110111 LUI 6/U; 0010111 AUIPC 7/U; 1101111 JAL 8/J; 1100111 JALR 9/I; 1110011 SYSTEM 10/I.
REQ-022 Any other opcode SHALL give command 0, imm_type 0, out_imm 0, out_illegal 1; otherwise out_illegal 0.
REQ-023 Immediates, sign-extended from inst[31] to DATA_WIDTH: I {inst[31:20]}; S {inst[31:25],inst[11:7]}; B {inst[31],inst[7],inst[30:25],inst[11:8],0}; U {inst[31:12],12'b0}; J {inst[31],inst[19:12],inst[20],inst[30:21],0}; R gives 0.
REQ-024 out_des SHALL equal inst[11:7] except STORE, BRANCH, illegal: 0.
REQ-025 decode_cnt SHALL increment by 1 per capture, wrapping from 2^CNT_WIDTH-1 to 0; flush does not decrement.

Reset
REQ-026 rst=0 SHALL immediately force out_valid=0, decode_cnt=0, all payload outputs 0, regardless of clk; an instruction presented during reset is not captured.
REQ-027 After rst deasserts, in_ready SHALL be 1 in the first cycle (given flush=0).

Verification
REQ-028 in_inst=0x00500093 (addi x1,x0,5), rdata1=0, out_ready=1 -> next cycle out_valid=1, out_command=1, out_imm_type=0x02, out_imm=5, out_des=1, decode_cnt=1.
REQ-029 in_inst=0x00112223 (sw x1,4(x2)) -> raddr1=2, raddr2=1; out_command=4, out_imm=4, out_des=0, out_imm_type=0x04.
REQ-030 in_inst=0xFE000EE3 (beq x0,x0,-4) -> out_imm=0xFFFFFFFC, out_command=5; then in_inst=0xFFFFFFFF -> out_illegal=1, out_command=0, out_imm=0.
REQ-031 Capture, then out_ready=0 for 3 cycles with in_valid=1 and new inst -> in_ready=0, payload unchanged; out_ready=1 -> new inst appears next cycle, decode_cnt increments exactly once more.
REQ-032 out_valid=1, flush=1 with in_valid=1 -> in_ready=0, next cycle out_valid=0, decode_cnt unchanged.
REQ-033 rst=0 asserted mid-cycle with out_valid=1, decode_cnt=7 -> out_valid=0, decode_cnt=0 before next clk edge; CNT_WIDTH=3 with 8 captures -> decode_cnt wraps to 0.
